lc3b_evict_buffer: RTL and testbench
====================================

Name: lc3b_evict_buffer

Overview:
- Parametrised dirty-line eviction (write-back) buffer between the L1 data cache and the L2/physical memory port.
- Queues evicted lines in FIFO order so L1 can refill without waiting on the writeback.
- Merges repeat evictions of a queued line in place, and serves L1 miss lookups from buffered lines.
- Generalises the fixed 128/256-bit line types to any line and tag width, with configurable depth.

Parameters:
- LINE_W, 128, data bits per line (128 = L1 line, 256 = L2 line).
- TAG_W, 12, line-address bits (word address with line-offset bits removed).
- DEPTH, 4, number of entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  L1 presents an evicted line.
- in_ready  output  1  buffer accepts the line this cycle.
- in_tag  input  TAG_W  line address of the evicted line.
- in_data  input  LINE_W  evicted line data.
- lookup_tag  input  TAG_W  line address of the current L1 miss.
- lookup_hit  output  1  a buffered entry matches lookup_tag.
- lookup_data  output  LINE_W  data of the youngest matching entry; 0 when no hit.
- mem_write  output  1  write request to lower level.
- mem_tag  output  TAG_W  line address of the head entry.
- mem_wdata  output  LINE_W  data of the head entry.
- mem_resp  input  1  lower level has completed the write.
- count  output  $clog2(DEPTH)+1  number of valid entries.
- empty  output  1  count == 0.

Behaviour:
- Reset, asynchronous on rst_n low:
  - all valid bits, head and tail pointers cleared;
  - count=0, empty=1, mem_write=0, lookup_hit=0;
  - mem_tag and mem_wdata are 0, with data storage contents don't-care;
  - any in-flight write is abandoned.
- Storage is a circular FIFO. Head and tail pointers wrap modulo DEPTH. count is held explicitly so full and empty are unambiguous.
- Head lock: whenever count>0 the head entry is being written downstream. The head is locked and never modified or merged into.
- Coalesce candidate: a valid, non-head entry whose tag == in_tag. At most one can exist.
- in_ready is combinational:
  - 1 if count<DEPTH, or
  - 1 if a coalesce candidate exists, even when full;
  - otherwise 0.
  - It is computed from the registered state only. A same-cycle pop does not make room, so there is no full pass-through.
- Accept is in_valid && in_ready:
  - With a coalesce candidate, overwrite that entry's data. count, tail and FIFO order are unchanged.
  - Otherwise write tag and data at the tail, advance the tail, and increment count.
  - in_tag equal to the head tag allocates a new entry, because the head is locked. The head and a younger copy may then coexist.
- Downstream port:
  - mem_write = (count>0). mem_tag and mem_wdata are driven from the head entry.
  - Request content stays stable until mem_resp.
  - On mem_resp && mem_write: invalidate the head, advance the head, decrement count at that edge. The next entry is presented the following cycle, giving one write per cycle max.
  - mem_resp while mem_write=0 is ignored.
- Simultaneous accept (allocating) and pop: count unchanged, both pointers advance.
- Simultaneous merge and pop: count decrements.
- Lookup:
  - Purely combinational over registered state; zero latency.
  - If several entries match, return the youngest in FIFO order.
  - A line accepted in the current cycle is not visible until the next cycle. The L1 controller does not issue a lookup for a line in the same cycle it evicts it.
- Width rule: tags are compared with full TAG_W equality. There is no partial or offset matching.

Test Plan:
- Reset then idle, DEPTH=4 -> count=0, empty=1, mem_write=0, in_ready=1, lookup_hit=0.
- Push tags 0x010,0x020,0x030,0x040 with mem_resp held 0 -> count=4, in_ready=0 for new tag 0x050. Stall one cycle, then pulse mem_resp -> mem_tag changes from 0x010 to 0x020 next cycle, count=3.
- While full, push tag 0x030 with data 0xAAAA…A -> in_ready=1, count stays 4, lookup_tag=0x030 returns 0xAAAA…A, FIFO write order unchanged.
- Head=0x010 being written, push 0x010 with new data -> new tail entry allocated (count+1). lookup_tag=0x010 returns the new data. Writes 0x010(old) then 0x010(new) issue in order.
- Same-cycle accept of 0x060 and mem_resp at count=2 -> count stays 2, head advances, 0x060 visible to lookup next cycle.
- Assert rst_n=0 mid-write with count=3 -> mem_write drops immediately (asynchronously), count=0. After release, operation resumes cleanly from an empty buffer.

Source files
------------

// File: rtl/lc3b_evict_buffer.sv
// Dirty-line write-back buffer between L1 and the lower memory level.
// Evicted lines queue in FIFO order; a repeat eviction of a queued (non-head)
// line overwrites it in place, and L1 misses can be served from buffered lines.
module lc3b_evict_buffer #(
  parameter int unsigned LINE_W = 128,
  parameter int unsigned TAG_W  = 12,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic [LINE_W-1:0]          in_data,
  input  logic [TAG_W-1:0]           lookup_tag,
  output logic                       lookup_hit,
  output logic [LINE_W-1:0]          lookup_data,
  output logic                       mem_write,
  output logic [TAG_W-1:0]           mem_tag,
  output logic [LINE_W-1:0]          mem_wdata,
  input  logic                       mem_resp,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [TAG_W-1:0]  r_tag  [DEPTH];
  logic [LINE_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic          w_nonempty;
  logic          w_cand;
  logic [PW-1:0] w_cand_idx;
  logic          w_accept;
  logic          w_merge;
  logic          w_alloc;
  logic          w_pop;

  assign w_nonempty = (r_count != '0);

  // Coalesce candidate: a valid entry other than the locked head whose tag matches in_tag.
  always_comb begin
    w_cand     = 1'b0;
    w_cand_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_valid[i] && (PW'(i) != r_head) && (r_tag[i] == in_tag)) begin
        w_cand     = 1'b1;
        w_cand_idx = PW'(i);
      end
    end
  end

  // Lookup walks from head to tail so the last match seen is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    idx         = '0;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      idx = r_head + PW'(k);
      if (r_valid[idx] && (r_tag[idx] == lookup_tag)) begin
        lookup_hit  = 1'b1;
        lookup_data = r_data[idx];
      end
    end
  end

  // Readiness depends only on registered state; a same-cycle pop never frees a slot.
  assign in_ready = (r_count < CW'(DEPTH)) || w_cand;
  assign w_accept = in_valid && in_ready;
  assign w_merge  = w_accept && w_cand;
  assign w_alloc  = w_accept && !w_cand;
  assign w_pop    = mem_resp && w_nonempty;

  // Head entry is the outstanding write; outputs are zeroed when nothing is queued.
  assign mem_write = w_nonempty;
  assign mem_tag   = w_nonempty ? r_tag[r_head]  : '0;
  assign mem_wdata = w_nonempty ? r_data[r_head] : '0;
  assign count     = r_count;
  assign empty     = !w_nonempty;

  // Pointer, occupancy and valid-bit bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      r_count <= r_count + CW'(w_alloc) - CW'(w_pop);
    end
  end

  // Line storage: allocate at tail or merge into the candidate; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_tag[r_tail]  <= in_tag;
      r_data[r_tail] <= in_data;
    end
    if (w_merge) begin
      r_data[w_cand_idx] <= in_data;
    end
  end

endmodule

// File: tb/tb_lc3b_evict_buffer.sv
// Self-checking bench: directed table, async-reset sequence, and a random run
// against a queue-based reference model.
module tb_lc3b_evict_buffer;

  localparam int LW = 128;
  localparam int TW = 12;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TW-1:0] in_tag = '0;
  logic [LW-1:0] in_data = '0;
  logic [TW-1:0] lookup_tag = '0;
  logic          lookup_hit;
  logic [LW-1:0] lookup_data;
  logic          mem_write;
  logic [TW-1:0] mem_tag;
  logic [LW-1:0] mem_wdata;
  logic          mem_resp = 1'b0;
  logic [2:0]    count;
  logic          empty;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lc3b_evict_buffer #(.LINE_W(LW), .TAG_W(TW), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_data(in_data),
    .lookup_tag(lookup_tag), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .mem_write(mem_write), .mem_tag(mem_tag), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
    .count(count), .empty(empty)
  );

  typedef struct {
    logic          v;
    logic [TW-1:0] tag;
    logic [LW-1:0] data;
    logic [TW-1:0] lt;
    logic          r;
    logic          e_ready;
    logic [2:0]    e_cnt;
    logic [TW-1:0] e_mtag;
    logic [LW-1:0] e_wdata;
    logic          e_hit;
    logic [LW-1:0] e_ldata;
  } vec_t;

  typedef struct {
    logic [TW-1:0] tag;
    logic [LW-1:0] data;
  } ent_t;

  vec_t vecs[19];
  ent_t q[$];

  function automatic logic [LW-1:0] dpat(input logic [TW-1:0] t);
    return {8{4'h0, t}};
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [TW-1:0] t, input logic [LW-1:0] d,
                       input logic [TW-1:0] lt, input logic r);
    in_valid   = v;
    in_tag     = t;
    in_data    = d;
    lookup_tag = lt;
    mem_resp   = r;
  endtask

  // Expected outputs from the model's current contents (oldest at q[0]).
  task automatic check_model();
    logic          e_ready;
    logic          e_hit;
    logic [LW-1:0] e_ld;
    e_ready = (q.size() < DP);
    for (int i = 1; i < q.size(); i++) if (q[i].tag == in_tag) e_ready = 1'b1;
    e_hit = 1'b0;
    e_ld  = '0;
    foreach (q[i]) if (q[i].tag == lookup_tag) begin e_hit = 1'b1; e_ld = q[i].data; end
    chk("m_ready", LW'(in_ready), LW'(e_ready));
    chk("m_hit",   LW'(lookup_hit), LW'(e_hit));
    chk("m_ldata", lookup_data, e_ld);
    chk("m_write", LW'(mem_write), LW'(q.size() > 0));
    chk("m_tag",   LW'(mem_tag), (q.size() > 0) ? LW'(q[0].tag) : '0);
    chk("m_wdata", mem_wdata, (q.size() > 0) ? q[0].data : '0);
    chk("m_count", LW'(count), LW'(q.size()));
    chk("m_empty", LW'(empty), LW'(q.size() == 0));
  endtask

  // Advance the model by one clock edge with the currently driven inputs.
  task automatic update_model();
    logic had = (q.size() > 0);
    logic rdy = (q.size() < DP);
    int   ci  = -1;
    ent_t e;
    for (int i = 1; i < q.size(); i++) if (q[i].tag == in_tag) ci = i;
    if (ci >= 0) rdy = 1'b1;
    if (in_valid && rdy) begin
      if (ci >= 0) begin
        e = q[ci]; e.data = in_data; q[ci] = e;
      end else begin
        e.tag = in_tag; e.data = in_data; q.push_back(e);
      end
    end
    if (mem_resp && had) void'(q.pop_front());
  endtask

  task automatic cyc(input logic v, input logic [TW-1:0] t, input logic [LW-1:0] d,
                     input logic [TW-1:0] lt, input logic r);
    drive(v, t, d, lt, r);
    @(negedge clk);
    check_model();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input int i, input logic v, input logic [TW-1:0] t, input logic [LW-1:0] d,
                      input logic [TW-1:0] lt, input logic r, input logic rdy, input logic [2:0] c,
                      input logic [TW-1:0] mt, input logic [LW-1:0] wd, input logic h,
                      input logic [LW-1:0] ld);
    vecs[i] = '{v, t, d, lt, r, rdy, c, mt, wd, h, ld};
  endtask

  initial begin
    logic [LW-1:0] da;
    logic [LW-1:0] d5;
    da = {32{4'hA}};
    d5 = {32{4'h5}};
    // Each row: inputs for the cycle, outputs expected before that cycle's edge.
    setv(0,  0, 12'h050, '0,           12'h010, 0, 1, 0, 12'h000, '0,           0, '0);
    setv(1,  1, 12'h010, dpat(12'h010), 12'h010, 0, 1, 0, 12'h000, '0,           0, '0);
    setv(2,  1, 12'h020, dpat(12'h020), 12'h010, 0, 1, 1, 12'h010, dpat(12'h010), 1, dpat(12'h010));
    setv(3,  1, 12'h030, dpat(12'h030), 12'h020, 0, 1, 2, 12'h010, dpat(12'h010), 1, dpat(12'h020));
    setv(4,  1, 12'h040, dpat(12'h040), 12'h030, 0, 1, 3, 12'h010, dpat(12'h010), 1, dpat(12'h030));
    setv(5,  1, 12'h050, dpat(12'h050), 12'h040, 0, 0, 4, 12'h010, dpat(12'h010), 1, dpat(12'h040));
    setv(6,  1, 12'h030, da,            12'h050, 0, 1, 4, 12'h010, dpat(12'h010), 0, '0);
    setv(7,  0, 12'h050, '0,            12'h030, 0, 0, 4, 12'h010, dpat(12'h010), 1, da);
    setv(8,  0, 12'h050, '0,            12'h010, 1, 0, 4, 12'h010, dpat(12'h010), 1, dpat(12'h010));
    setv(9,  0, 12'h050, '0,            12'h020, 0, 1, 3, 12'h020, dpat(12'h020), 1, dpat(12'h020));
    setv(10, 1, 12'h020, d5,            12'h040, 0, 1, 3, 12'h020, dpat(12'h020), 1, dpat(12'h040));
    setv(11, 0, 12'h050, '0,            12'h020, 1, 0, 4, 12'h020, dpat(12'h020), 1, d5);
    setv(12, 0, 12'h050, '0,            12'h020, 1, 1, 3, 12'h030, da,            1, d5);
    setv(13, 1, 12'h060, dpat(12'h060), 12'h060, 1, 1, 2, 12'h040, dpat(12'h040), 0, '0);
    setv(14, 0, 12'h050, '0,            12'h060, 0, 1, 2, 12'h020, d5,            1, dpat(12'h060));
    setv(15, 0, 12'h050, '0,            12'h020, 1, 1, 2, 12'h020, d5,            1, d5);
    setv(16, 0, 12'h050, '0,            12'h010, 1, 1, 1, 12'h060, dpat(12'h060), 0, '0);
    setv(17, 0, 12'h050, '0,            12'h010, 1, 1, 0, 12'h000, '0,            0, '0);
    setv(18, 0, 12'h050, '0,            12'h010, 0, 1, 0, 12'h000, '0,            0, '0);

    do_reset();

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].tag, vecs[i].data, vecs[i].lt, vecs[i].r);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), LW'(in_ready),   LW'(vecs[i].e_ready));
      chk($sformatf("v%0d_count", i), LW'(count),      LW'(vecs[i].e_cnt));
      chk($sformatf("v%0d_empty", i), LW'(empty),      LW'(vecs[i].e_cnt == 0));
      chk($sformatf("v%0d_write", i), LW'(mem_write),  LW'(vecs[i].e_cnt != 0));
      chk($sformatf("v%0d_mtag", i),  LW'(mem_tag),    LW'(vecs[i].e_mtag));
      chk($sformatf("v%0d_wdata", i), mem_wdata,       vecs[i].e_wdata);
      chk($sformatf("v%0d_hit", i),   LW'(lookup_hit), LW'(vecs[i].e_hit));
      chk($sformatf("v%0d_ldata", i), lookup_data,     vecs[i].e_ldata);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of an outstanding write with three entries queued.
    do_reset();
    cyc(1, 12'h111, dpat(12'h111), 12'h000, 0);
    cyc(1, 12'h222, dpat(12'h222), 12'h111, 0);
    cyc(1, 12'h333, dpat(12'h333), 12'h222, 0);
    drive(0, 12'h000, '0, 12'h222, 0);
    #2;
    chk("ar_pre_count", LW'(count), LW'(3));
    rst_n = 1'b0;
    #1;
    chk("ar_write", LW'(mem_write), '0);
    chk("ar_count", LW'(count), '0);
    chk("ar_empty", LW'(empty), LW'(1));
    chk("ar_hit",   LW'(lookup_hit), '0);
    chk("ar_tag",   LW'(mem_tag), '0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 12'h000, '0, 12'h111, 1);
    cyc(1, 12'h444, dpat(12'h444), 12'h111, 0);
    cyc(0, 12'h000, '0, 12'h444, 1);
    cyc(0, 12'h000, '0, 12'h444, 0);

    // Random traffic against the model; a small tag pool forces merges and duplicates.
    for (int n = 0; n < 600; n++) begin
      logic [LW-1:0] rd;
      rd = {$urandom, $urandom, $urandom, $urandom};
      cyc(($urandom_range(0, 9) < 6), 12'h100 + 12'($urandom_range(0, 5)), rd,
          12'h100 + 12'($urandom_range(0, 6)), ($urandom_range(0, 9) < 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
